risc_multicycle_core: RTL

// - Parametrised multi-cycle successor to the 4-bit single-cycle RISC processor.
// - Fetches from external instruction memory and accesses external data memory over req/ready handshakes, so wait states are tolerated.
// - Adds conditional branch, jump, halt and a sticky zero flag.
// - Sits between the instruction ROM/RAM and the data RAM as the top-level compute core.

---
 rtl/risc_multicycle_core.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/risc_multicycle_core.sv
// rtl/risc_multicycle_core.sv - multi-cycle RISC core with handshaked instruction and data memory ports
module risc_multicycle_core #(
    parameter int DATA_W = 4,
    parameter int REG_AW = 2,
    parameter int PC_W   = 4,
    localparam int INSTR_W = 4 + 2 * REG_AW
) (
    input  logic               clk,
    input  logic               reset,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic               imem_ready,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               dmem_req,
    output logic               dmem_we,
    output logic [DATA_W-1:0]  dmem_addr,
    output logic [DATA_W-1:0]  dmem_wdata,
    input  logic               dmem_ready,
    input  logic [DATA_W-1:0]  dmem_rdata,
    output logic               halted,
    output logic               zero_flag,
    output logic               retire
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        EXEC  = 2'd1,
        MEM   = 2'd2,
        HALT  = 2'd3
    } state_t;

    localparam logic [3:0] OP_LOAD  = 4'b1000;
    localparam logic [3:0] OP_STORE = 4'b1001;
    localparam logic [3:0] OP_BEQZ  = 4'b1010;
    localparam logic [3:0] OP_JMP   = 4'b1011;
    localparam logic [3:0] OP_HALT  = 4'b1111;

    state_t              state, state_nx;
    logic [PC_W-1:0]     pc;
    logic [INSTR_W-1:0]  ir;
    logic [DATA_W-1:0]   rf [2**REG_AW];
    logic                zero_q;
    logic                retire_q;

    logic [3:0]          opcode;
    logic [REG_AW-1:0]   rs, rt;
    logic [DATA_W-1:0]   op_a, op_b, alu_res;
    logic [PC_W-1:0]     branch_tgt;

    assign opcode     = ir[INSTR_W-1 -: 4];
    assign rs         = ir[2*REG_AW-1 -: REG_AW];
    assign rt         = ir[REG_AW-1:0];
    assign op_a       = rf[rs];
    assign op_b       = rf[rt];
    // Cast truncates or zero-extends the register value to the PC width.
    assign branch_tgt = PC_W'(op_b);

    always_comb begin
        alu_res = '0;
        case (opcode)
            4'b0000: alu_res = op_a & op_b;
            4'b0001: alu_res = op_a | op_b;
            4'b0010: alu_res = op_a + op_b;
            4'b0011: alu_res = op_a - op_b;
            4'b0100: alu_res = op_a ^ op_b;
            4'b0101: alu_res = ~op_a;
            4'b0110: alu_res = op_a + DATA_W'(1);
            4'b0111: alu_res = op_a - DATA_W'(1);
            default: alu_res = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= FETCH;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            FETCH: if (imem_ready) state_nx = EXEC;
            EXEC: begin
                if (opcode == OP_LOAD || opcode == OP_STORE) begin
                    state_nx = MEM;
                end else if (opcode == OP_HALT) begin
                    state_nx = HALT;
                end else begin
                    state_nx = FETCH;
                end
            end
            MEM:     if (dmem_ready) state_nx = FETCH;
            HALT:    state_nx = HALT;
            default: state_nx = FETCH;
        endcase
    end

    // Every output is gated by reset so requests drop in the same cycle reset rises.
    assign imem_req   = !reset && (state == FETCH);
    assign imem_addr  = reset ? '0 : pc;
    assign dmem_req   = !reset && (state == MEM);
    assign dmem_we    = dmem_req && (opcode == OP_STORE);
    assign dmem_addr  = reset ? '0 : op_b;
    assign dmem_wdata = reset ? '0 : op_a;
    assign halted     = !reset && (state == HALT);
    assign zero_flag  = !reset && zero_q;
    assign retire     = !reset && retire_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc       <= '0;
            ir       <= '0;
            zero_q   <= 1'b0;
            retire_q <= 1'b0;
            for (int i = 0; i < 2**REG_AW; i++) begin
                rf[i] <= DATA_W'(i + 1);
            end
        end else begin
            retire_q <= 1'b0;
            case (state)
                FETCH: begin
                    if (imem_ready) begin
                        ir <= imem_rdata;
                        pc <= pc + PC_W'(1);
                    end
                end
                EXEC: begin
                    if (!opcode[3]) begin
                        rf[rs]   <= alu_res;
                        zero_q   <= (alu_res == '0);
                        retire_q <= 1'b1;
                    end else if (opcode == OP_BEQZ) begin
                        if (op_a == '0) pc <= branch_tgt;
                        retire_q <= 1'b1;
                    end else if (opcode == OP_JMP) begin
                        pc       <= branch_tgt;
                        retire_q <= 1'b1;
                    end else if (opcode != OP_LOAD && opcode != OP_STORE) begin
                        retire_q <= 1'b1;
                    end
                end
                MEM: begin
                    if (dmem_ready) begin
                        if (opcode == OP_LOAD) rf[rs] <= dmem_rdata;
                        retire_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
